// File: rtl/flexible_deque.sv
// Double-ended queue on an N-entry circular buffer. One command per cycle; pops and
// replaces return the removed word on PopData with a one-cycle PopValid pulse.
module flexible_deque #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 CmdValid,
  input  logic [2:0]           CMD,
  input  logic [W-1:0]         DataIn,
  output logic [W-1:0]         Front,
  output logic [W-1:0]         Back,
  output logic [W-1:0]         PopData,
  output logic                 PopValid,
  output logic [$clog2(N):0]   Count,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW:0] CountMax = (AW+1)'(N);

  localparam logic [2:0] CmdPushBack     = 3'b001;
  localparam logic [2:0] CmdPushFront    = 3'b010;
  localparam logic [2:0] CmdPopFront     = 3'b011;
  localparam logic [2:0] CmdPopBack      = 3'b100;
  localparam logic [2:0] CmdClear        = 3'b101;
  localparam logic [2:0] CmdReplaceFront = 3'b110;

  logic [W-1:0]  mem [N];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] head_m1, head_p1, tail_m1;

  // Power-of-two depth makes modulo-N wrap the natural pointer overflow.
  assign head_m1 = head_q - 1'b1;
  assign head_p1 = head_q + 1'b1;
  assign tail_m1 = tail_q - 1'b1;

  assign Empty     = (count_q == '0);
  assign Full      = (count_q == CountMax);
  assign Count     = count_q;
  assign Front     = Empty ? '0 : mem[head_q];
  assign Back      = Empty ? '0 : mem[tail_m1];
  assign PopData   = pop_data_q;
  assign PopValid  = pop_valid_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = tail_q;
    if (CmdValid) begin
      case (CMD)
        CmdPushBack: begin
          if (Full) begin
            overflow_d = 1'b1;
          end else begin
            we      = 1'b1;
            waddr   = tail_q;
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        CmdPushFront: begin
          if (Full) begin
            overflow_d = 1'b1;
          end else begin
            we      = 1'b1;
            waddr   = head_m1;
            head_d  = head_m1;
            count_d = count_q + 1'b1;
          end
        end
        CmdPopFront: begin
          if (Empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = mem[head_q];
            pop_valid_d = 1'b1;
            head_d      = head_p1;
            count_d     = count_q - 1'b1;
          end
        end
        CmdPopBack: begin
          if (Empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = mem[tail_m1];
            pop_valid_d = 1'b1;
            tail_d      = tail_m1;
            count_d     = count_q - 1'b1;
          end
        end
        CmdClear: begin
          head_d      = '0;
          tail_d      = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
        CmdReplaceFront: begin
          if (Empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = mem[head_q];
            pop_valid_d = 1'b1;
            we          = 1'b1;
            waddr       = head_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; Empty masks stale contents on Front/Back.
  always_ff @(posedge clk) begin
    if (we && Reset) begin
      mem[waddr] <= DataIn;
    end
  end

endmodule

// File: tb/tb_flexible_deque.sv
// Directed bench for flexible_deque (N=4, W=8) with a PopData scoreboard queue.
module tb_flexible_deque;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  localparam logic [2:0] Hold = 3'b000, PushBack = 3'b001, PushFront = 3'b010,
                         PopFront = 3'b011, PopBack = 3'b100, Clear = 3'b101,
                         Replace = 3'b110, Reserved = 3'b111;

  logic         clk = 1'b0;
  logic         Reset;
  logic         CmdValid;
  logic [2:0]   CMD;
  logic [W-1:0] DataIn;
  logic [W-1:0] Front, Back, PopData;
  logic         PopValid;
  logic [2:0]   Count;
  logic         Empty, Full, Overflow, Underflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  flexible_deque #(.N(N), .W(W)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CMD      (CMD),
    .DataIn   (DataIn),
    .Front    (Front),
    .Back     (Back),
    .PopData  (PopData),
    .PopValid (PopValid),
    .Count    (Count),
    .Empty    (Empty),
    .Full     (Full),
    .Overflow (Overflow),
    .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; the command is taken on the next one.
  task automatic cmd(input logic [2:0] c, input logic [W-1:0] d);
    CmdValid = 1'b1;
    CMD      = c;
    DataIn   = d;
    @(posedge clk);
    #1;
    CmdValid = 1'b0;
    CMD      = Hold;
    DataIn   = '0;
  endtask

  task automatic pop_cmd(input logic [2:0] c, input logic [W-1:0] d, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    cmd(c, d);
  endtask

  // Monitor: every PopValid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (PopValid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got PopValid=1 data %0h expected no pop", PopData);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (PopData !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", PopData, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset    = 1'b0;
    CmdValid = 1'b0;
    CMD      = Hold;
    DataIn   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(Empty), 1);
    check("rst_full", 32'(Full), 0);
    check("rst_count", 32'(Count), 0);
    check("rst_front", 32'(Front), 0);
    check("rst_back", 32'(Back), 0);
    check("rst_popvalid", 32'(PopValid), 0);
    check("rst_popdata", 32'(PopData), 0);
    Reset = 1'b1;

    cmd(PushBack, 8'h11);
    check("first_cmd_count", 32'(Count), 1);
    cmd(PushBack, 8'h22);
    cmd(PushFront, 8'h33);
    check("front_33", 32'(Front), 32'h33);
    check("back_22", 32'(Back), 32'h22);
    check("count_3", 32'(Count), 3);

    cmd(PushBack, 8'h44);
    check("full", 32'(Full), 1);
    check("back_44", 32'(Back), 32'h44);
    cmd(PushFront, 8'h55);
    check("overflow", 32'(Overflow), 1);
    check("ovf_count", 32'(Count), 4);
    check("ovf_front", 32'(Front), 32'h33);

    // Idle forms must not disturb state
    cmd(Reserved, 8'hEE);
    CMD = PushBack; DataIn = 8'hEE;
    @(posedge clk); #1;
    CMD = Hold; DataIn = '0;
    check("idle_count", 32'(Count), 4);
    check("idle_back", 32'(Back), 32'h44);

    pop_cmd(PopFront, 8'h00, 8'h33);
    pop_cmd(PopBack, 8'h00, 8'h44);
    check("pop_count", 32'(Count), 2);
    check("pop_front", 32'(Front), 32'h11);
    check("pop_back", 32'(Back), 32'h22);
    check("ovf_sticky", 32'(Overflow), 1);

    pop_cmd(Replace, 8'h99, 8'h11);
    check("repl_front", 32'(Front), 32'h99);
    check("repl_count", 32'(Count), 2);
    cmd(Clear, 8'h00);
    check("clr_empty", 32'(Empty), 1);
    check("clr_overflow", 32'(Overflow), 0);
    check("clr_popvalid", 32'(PopValid), 0);

    cmd(PopBack, 8'h00);
    check("underflow", 32'(Underflow), 1);
    check("unf_popvalid", 32'(PopValid), 0);
    check("unf_popdata", 32'(PopData), 32'h11);
    check("unf_count", 32'(Count), 0);
    cmd(Clear, 8'h00);
    check("clr_underflow", 32'(Underflow), 0);

    // Both pointers walk backwards through several wraps; pops come out in push order.
    cmd(PushBack, 8'hA0);
    for (int i = 0; i < 10; i++) begin
      cmd(PushFront, 8'(8'hB0 + i));
      pop_cmd(PopBack, 8'h00, (i == 0) ? 8'hA0 : 8'(8'hB0 + i - 1));
    end
    check("wrap_count", 32'(Count), 1);
    check("wrap_front", 32'(Front), 32'hB9);

    // Asynchronous reset between edges
    cmd(PushBack, 8'h01);
    cmd(PushBack, 8'h02);
    check("pre_rst_count", 32'(Count), 3);
    #2;
    Reset = 1'b0;
    #1;
    check("async_empty", 32'(Empty), 1);
    check("async_count", 32'(Count), 0);
    check("async_front", 32'(Front), 0);
    check("async_back", 32'(Back), 0);
    @(posedge clk); #1;
    Reset = 1'b1;
    cmd(PushFront, 8'h5A);
    check("post_rst_front", 32'(Front), 32'h5A);
    check("post_rst_count", 32'(Count), 1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
